spi_pixel_stream: RTL and testbench

//  SPI slave front end for the grayscale/Sobel pipeline. It oversamples the SPI pins in the
//  clk_i domain and deserialises MSB-first RGB pixels into a one-cycle px_valid_o strobe that

---
 rtl/spi_pixel_stream_if.sv | 31 +++
 rtl/spi_pixel_stream.sv | 175 +++++++++++++++++
 tb/tb_spi_pixel_stream.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_pixel_stream_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_pixel_stream_if : SPI pins plus pixel/result handshake bundle      |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
interface spi_pixel_stream_if #(
  parameter int PIXEL_BITS = 24,
  parameter int OUT_BITS   = 8
);
  logic                  spi_sck_i;
  logic                  spi_cs_i;
  logic                  spi_sdi_i;
  logic                  spi_sdo_o;
  logic [PIXEL_BITS-1:0] px_o;
  logic                  px_valid_o;
  logic [OUT_BITS-1:0]   res_px_i;
  logic                  res_ready_i;
  logic                  overrun_o;
  logic                  busy_o;

  modport slave (
    input  spi_sck_i, spi_cs_i, spi_sdi_i, res_px_i, res_ready_i,
    output spi_sdo_o, px_o, px_valid_o, overrun_o, busy_o
  );

  modport master (
    output spi_sck_i, spi_cs_i, spi_sdi_i, res_px_i, res_ready_i,
    input  spi_sdo_o, px_o, px_valid_o, overrun_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/spi_pixel_stream.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_pixel_stream : oversampled SPI mode-0 slave, RGB pixel deserialiser|
// | with full-duplex return of filter result pixels. Rev 1.0               |
// +----------------------------------------------------------------------+
module spi_pixel_stream #(
  parameter int PIXEL_BITS  = 24,
  parameter int OUT_BITS    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  wire logic         clk_i,
  input  wire logic         reset_i,
  spi_pixel_stream_if.slave bus
);

  localparam int                c_CNT_W = $clog2(PIXEL_BITS + 1);
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(PIXEL_BITS - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t r_state, w_state_nxt;

  logic [SYNC_STAGES-1:0] r_sck_sync, r_cs_sync, r_sdi_sync;
  logic                   r_sck_d, r_cs_d, r_busy;
  logic                   w_sck_s, w_cs_s, w_sdi_s;
  logic                   w_sck_rise, w_sck_fall, w_cs_fall, w_cs_rise;

  logic [PIXEL_BITS-1:0] r_rx_shift, r_tx_shift, r_px;
  logic [OUT_BITS-1:0]   r_hold_reg;
  logic                  r_hold_full, r_overrun, r_sdo, r_px_valid, r_valid_pend;
  logic                  r_skip_fall;
  logic [c_CNT_W-1:0]    r_bit_cnt;

  logic                  w_frame_start, w_word_load, w_rx_bit, w_last_bit;
  logic                  w_tx_shift, w_abort;
  logic [OUT_BITS-1:0]   w_hold_sel;
  logic [PIXEL_BITS-1:0] w_load_word;

  // Pin synchronisers plus one edge-detect flop on sck and cs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_sck_sync <= '0;
      r_cs_sync  <= '1;
      r_sdi_sync <= '0;
      r_sck_d    <= 1'b0;
      r_cs_d     <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], bus.spi_sck_i};
      r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0],  bus.spi_cs_i};
      r_sdi_sync <= {r_sdi_sync[SYNC_STAGES-2:0], bus.spi_sdi_i};
      r_sck_d    <= w_sck_s;
      r_cs_d     <= w_cs_s;
      r_busy     <= ~w_cs_s;
    end
  end

  assign w_sck_s    = r_sck_sync[SYNC_STAGES-1];
  assign w_cs_s     = r_cs_sync[SYNC_STAGES-1];
  assign w_sdi_s    = r_sdi_sync[SYNC_STAGES-1];
  assign w_sck_rise =  w_sck_s & ~r_sck_d;
  assign w_sck_fall = ~w_sck_s &  r_sck_d;
  assign w_cs_fall  = ~w_cs_s  &  r_cs_d;
  assign w_cs_rise  =  w_cs_s  & ~r_cs_d;

  assign w_hold_sel  = r_hold_full ? r_hold_reg : '0;
  assign w_load_word = PIXEL_BITS'(w_hold_sel) << (PIXEL_BITS - OUT_BITS);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_frame_start = 1'b0;
    w_word_load   = 1'b0;
    w_rx_bit      = 1'b0;
    w_last_bit    = 1'b0;
    w_tx_shift    = 1'b0;
    w_abort       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cs_fall) begin
          w_state_nxt   = ST_SHIFT;
          w_frame_start = 1'b1;
          w_word_load   = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (w_cs_rise) begin
          w_state_nxt = ST_IDLE;
          w_abort     = 1'b1;
        end else if (w_sck_rise) begin
          w_rx_bit = 1'b1;
          if (r_bit_cnt == c_LAST) begin
            w_last_bit  = 1'b1;
            w_word_load = 1'b1;
          end
        end else if (w_sck_fall && !r_skip_fall) begin
          w_tx_shift = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_rx_shift   <= '0;
      r_tx_shift   <= '0;
      r_px         <= '0;
      r_hold_reg   <= '0;
      r_hold_full  <= 1'b0;
      r_overrun    <= 1'b0;
      r_sdo        <= 1'b0;
      r_px_valid   <= 1'b0;
      r_valid_pend <= 1'b0;
      r_skip_fall  <= 1'b0;
      r_bit_cnt    <= '0;
    end else begin
      r_valid_pend <= w_last_bit;
      r_px_valid   <= r_valid_pend;
      if (r_valid_pend) r_px <= r_rx_shift;

      if (w_frame_start) begin
        r_bit_cnt   <= '0;
        r_skip_fall <= 1'b0;
      end

      // A load on the final rise is followed by a fall that must not shift,
      // so the fresh MSB is held for the whole first bit of the next word.
      if (w_rx_bit) begin
        r_rx_shift  <= {r_rx_shift[PIXEL_BITS-2:0], w_sdi_s};
        r_bit_cnt   <= w_last_bit ? '0 : r_bit_cnt + c_CNT_W'(1);
        r_skip_fall <= w_last_bit;
      end

      if (w_tx_shift) begin
        r_tx_shift <= r_tx_shift << 1;
        r_sdo      <= r_tx_shift[PIXEL_BITS-2];
      end

      if (w_word_load) begin
        r_tx_shift  <= w_load_word;
        r_sdo       <= w_load_word[PIXEL_BITS-1];
        r_hold_full <= 1'b0;
      end

      if (w_abort) begin
        r_bit_cnt   <= '0;
        r_tx_shift  <= '0;
        r_sdo       <= 1'b0;
        r_skip_fall <= 1'b0;
      end

      if (bus.res_ready_i) begin
        r_hold_reg  <= bus.res_px_i;
        r_hold_full <= 1'b1;
        if (r_hold_full && !w_word_load) r_overrun <= 1'b1;
      end
    end
  end

  assign bus.spi_sdo_o  = r_sdo;
  assign bus.px_o       = r_px;
  assign bus.px_valid_o = r_px_valid;
  assign bus.overrun_o  = r_overrun;
  assign bus.busy_o     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_spi_pixel_stream.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_spi_pixel_stream : directed self-checking bench for spi_pixel_stream|
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module tb_spi_pixel_stream;

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc = 0;
  int   n_valid = 0;
  int   valid_cyc = 0;
  int   rise_cyc = 0;
  logic [23:0] last_px = '0;
  logic [23:0] px_q[$];

  spi_pixel_stream_if #(.PIXEL_BITS(24), .OUT_BITS(8)) bus ();

  spi_pixel_stream #(.PIXEL_BITS(24), .OUT_BITS(8), .SYNC_STAGES(2)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.px_valid_o === 1'b1) begin
      n_valid   <= n_valid + 1;
      last_px   <= bus.px_o;
      valid_cyc <= cyc;
      px_q.push_back(bus.px_o);
    end
  end

  // Master drives SDI after each fall, samples SDO on each rise; SCK = clk/8.
  task automatic xfer_bits(input logic [23:0] tx, input int nbits, output logic [23:0] rx);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      bus.spi_sdi_i = tx[23-i];
      repeat (4) @(negedge clk);
      bus.spi_sck_i = 1'b1;
      rx = {rx[22:0], bus.spi_sdo_o};
      rise_cyc = cyc;
      repeat (4) @(negedge clk);
      bus.spi_sck_i = 1'b0;
    end
  endtask

  task automatic frame_begin();
    @(negedge clk);
    bus.spi_cs_i = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic frame_end();
    repeat (4) @(negedge clk);
    bus.spi_cs_i = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic pulse_ready(input logic [7:0] v);
    @(negedge clk);
    bus.res_px_i    = v;
    bus.res_ready_i = 1'b1;
    @(negedge clk);
    bus.res_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.spi_sck_i = 1'($urandom_range(0, 1));
      bus.spi_cs_i  = 1'($urandom_range(0, 1));
      bus.spi_sdi_i = 1'($urandom_range(0, 1));
      n_tests++;
      if ({bus.px_o, bus.px_valid_o, bus.spi_sdo_o, bus.overrun_o, bus.busy_o} !== 28'h0) begin
        n_fail++;
        $display("FAIL reset_outputs: px=%h valid=%b sdo=%b ovr=%b busy=%b, required all 0",
                 bus.px_o, bus.px_valid_o, bus.spi_sdo_o, bus.overrun_o, bus.busy_o);
      end
    end
    bus.spi_sck_i = 1'b0;
    bus.spi_cs_i  = 1'b1;
    bus.spi_sdi_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    n_tests++;
    if (n_valid !== 0 || bus.busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: pulses=%0d busy=%b, required 0 and 0", n_valid, bus.busy_o);
    end
  endtask

  task automatic test_one_word();
    logic [23:0] rx;
    int n0;
    n0 = n_valid;
    frame_begin();
    n_tests++;
    if (bus.busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_in_frame: got %b required 1", bus.busy_o);
    end
    xfer_bits(24'hA5C3F0, 24, rx);
    frame_end();
    n_tests++;
    if (n_valid !== n0 + 1) begin
      n_fail++;
      $display("FAIL one_word_pulses: got %0d required %0d", n_valid - n0, 1);
    end
    n_tests++;
    if (last_px !== 24'hA5C3F0 || bus.px_o !== 24'hA5C3F0) begin
      n_fail++;
      $display("FAIL one_word_px: got %h/%h required a5c3f0", last_px, bus.px_o);
    end
    n_tests++;
    if (valid_cyc - rise_cyc !== 4) begin
      n_fail++;
      $display("FAIL one_word_latency: got %0d required 4", valid_cyc - rise_cyc);
    end
    n_tests++;
    if (rx !== 24'h000000) begin
      n_fail++;
      $display("FAIL one_word_sdo: got %h required 000000", rx);
    end
    n_tests++;
    if (bus.busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_after_frame: got %b required 0", bus.busy_o);
    end
  endtask

  task automatic test_loopback();
    logic [23:0] rx;
    pulse_ready(8'h7E);
    repeat (2) @(negedge clk);
    frame_begin();
    xfer_bits(24'h5A5A5A, 24, rx);
    frame_end();
    n_tests++;
    if (rx !== 24'h7E0000) begin
      n_fail++;
      $display("FAIL loopback_sdo: got %h required 7e0000", rx);
    end
    n_tests++;
    if (bus.px_o !== 24'h5A5A5A || bus.overrun_o !== 1'b0) begin
      n_fail++;
      $display("FAIL loopback_px: px=%h ovr=%b required 5a5a5a 0", bus.px_o, bus.overrun_o);
    end
  endtask

  task automatic test_abort();
    logic [23:0] rx;
    int n0;
    n0 = n_valid;
    frame_begin();
    xfer_bits(24'hFFFFFF, 10, rx);
    frame_end();
    n_tests++;
    if (n_valid !== n0 || bus.px_o !== 24'h5A5A5A) begin
      n_fail++;
      $display("FAIL abort_discard: pulses=%0d px=%h required 0 5a5a5a", n_valid - n0, bus.px_o);
    end
    frame_begin();
    xfer_bits(24'h123456, 24, rx);
    frame_end();
    n_tests++;
    if (n_valid !== n0 + 1 || bus.px_o !== 24'h123456) begin
      n_fail++;
      $display("FAIL abort_next_word: pulses=%0d px=%h required 1 123456", n_valid - n0, bus.px_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] rx1, rx2, rx3;
    px_q.delete();
    frame_begin();
    xfer_bits(24'h010203, 24, rx1);
    // The next word is already loaded here, so this result rides on word 3.
    pulse_ready(8'h3C);
    xfer_bits(24'h0A0B0C, 24, rx2);
    xfer_bits(24'hFFFFFF, 24, rx3);
    frame_end();
    n_tests++;
    if (px_q.size() !== 3) begin
      n_fail++;
      $display("FAIL burst_pulses: got %0d required 3", px_q.size());
    end else begin
      n_tests++;
      if (px_q[0] !== 24'h010203 || px_q[1] !== 24'h0A0B0C || px_q[2] !== 24'hFFFFFF) begin
        n_fail++;
        $display("FAIL burst_order: got %h %h %h required 010203 0a0b0c ffffff",
                 px_q[0], px_q[1], px_q[2]);
      end
    end
    n_tests++;
    if (rx1 !== 24'h0 || rx2 !== 24'h0 || rx3 !== 24'h3C0000) begin
      n_fail++;
      $display("FAIL burst_sdo: got %h %h %h required 000000 000000 3c0000", rx1, rx2, rx3);
    end
  endtask

  task automatic test_coincident();
    logic [23:0] rx1, rx2;
    pulse_ready(8'h5A);
    repeat (2) @(negedge clk);
    @(negedge clk);
    bus.spi_cs_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.res_px_i    = 8'h66;
    bus.res_ready_i = 1'b1;
    @(negedge clk);
    bus.res_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    xfer_bits(24'h111111, 24, rx1);
    xfer_bits(24'h222222, 24, rx2);
    frame_end();
    n_tests++;
    if (rx1 !== 24'h5A0000 || rx2 !== 24'h660000) begin
      n_fail++;
      $display("FAIL coincident_sdo: got %h %h required 5a0000 660000", rx1, rx2);
    end
    n_tests++;
    if (bus.overrun_o !== 1'b0) begin
      n_fail++;
      $display("FAIL coincident_overrun: got %b required 0", bus.overrun_o);
    end
  endtask

  task automatic test_overrun();
    logic [23:0] rx;
    pulse_ready(8'h11);
    pulse_ready(8'h22);
    repeat (2) @(negedge clk);
    n_tests++;
    if (bus.overrun_o !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_set: got %b required 1", bus.overrun_o);
    end
    frame_begin();
    xfer_bits(24'h333333, 24, rx);
    frame_end();
    n_tests++;
    if (rx !== 24'h220000 || bus.overrun_o !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_word: sdo=%h ovr=%b required 220000 1", rx, bus.overrun_o);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [23:0] rx;
    int n0;
    frame_begin();
    xfer_bits(24'hFFFFFF, 5, rx);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({bus.px_o, bus.px_valid_o, bus.spi_sdo_o, bus.overrun_o, bus.busy_o} !== 28'h0) begin
      n_fail++;
      $display("FAIL midframe_reset: px=%h valid=%b sdo=%b ovr=%b busy=%b, required all 0",
               bus.px_o, bus.px_valid_o, bus.spi_sdo_o, bus.overrun_o, bus.busy_o);
    end
    bus.spi_cs_i  = 1'b1;
    bus.spi_sck_i = 1'b0;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    n0 = n_valid;
    frame_begin();
    xfer_bits(24'hC0FFEE, 24, rx);
    frame_end();
    n_tests++;
    if (n_valid !== n0 + 1 || bus.px_o !== 24'hC0FFEE) begin
      n_fail++;
      $display("FAIL after_reset_word: pulses=%0d px=%h required 1 c0ffee", n_valid - n0, bus.px_o);
    end
  endtask

  initial begin
    rst             = 1'b1;
    bus.spi_sck_i   = 1'b0;
    bus.spi_cs_i    = 1'b1;
    bus.spi_sdi_i   = 1'b0;
    bus.res_px_i    = '0;
    bus.res_ready_i = 1'b0;
    test_reset();
    test_one_word();
    test_loopback();
    test_abort();
    test_back_to_back();
    test_coincident();
    test_overrun();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
